// File: rtl/inst_buffer_pkg.sv
// rtl/inst_buffer_pkg.sv - shared widths and sizes for the fetch-to-decode instruction buffer
package inst_buffer_pkg;

   // Fetch batch shape and machine word sizes.
   localparam int IF_BATCH_SIZE   = 4;
   localparam int INST_WIDTH      = 32;
   localparam int INST_ADDR_WIDTH = 32;

   // Instruction buffer geometry.
   localparam int IB_DEPTH     = 16;
   localparam int IB_OUT_WIDTH = 2;

   // Byte distance between consecutive instruction slots in a batch.
   localparam int INST_BYTES = INST_WIDTH / 8;

endpackage

// File: rtl/inst_buffer_compact.sv
// rtl/inst_buffer_compact.sv - prefix popcount of a fetch valid mask
module inst_compact
   import inst_buffer_pkg::*;
#(
   parameter int N     = IF_BATCH_SIZE,
   parameter int OFF_W = $clog2(N + 1)
) (
   input  logic [N-1:0]            mask,
   output logic [N-1:0][OFF_W-1:0] offset,
   output logic [OFF_W-1:0]        total
);

   logic [OFF_W-1:0] acc;

   // Each slot's offset is the number of valid slots below it; the running sum ends as the total.
   always_comb begin
      acc    = '0;
      offset = '0;
      for (int i = 0; i < N; i++) begin
         offset[i] = acc;
         acc       = acc + OFF_W'(mask[i]);
      end
      total = acc;
   end

endmodule

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - circular instruction queue between fetch and decode
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH      = IB_DEPTH,
   parameter int IN_WIDTH   = IF_BATCH_SIZE,
   parameter int INST_WIDTH = inst_buffer_pkg::INST_WIDTH,
   parameter int ADDR_WIDTH = INST_ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic [INST_WIDTH-1:0]   in_inst_0,
   input  logic [INST_WIDTH-1:0]   in_inst_1,
   input  logic [INST_WIDTH-1:0]   in_inst_2,
   input  logic [INST_WIDTH-1:0]   in_inst_3,
   input  logic [ADDR_WIDTH-1:0]   in_pc,
   input  logic [IN_WIDTH-1:0]     in_inst_valid,
   output logic                    in_ready,
   output logic [INST_WIDTH-1:0]   out_inst_0,
   output logic [INST_WIDTH-1:0]   out_inst_1,
   output logic [ADDR_WIDTH-1:0]   out_pc_0,
   output logic [ADDR_WIDTH-1:0]   out_pc_1,
   output logic [IB_OUT_WIDTH-1:0] out_valid,
   input  logic                    dec_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OFF_W = $clog2(IN_WIDTH + 1);

   logic [INST_WIDTH-1:0] mem_inst [DEPTH];
   logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] head_p1;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] enq_n;
   logic [CNT_W-1:0] deq_n;
   logic             do_enq;
   logic             do_deq;

   logic [INST_WIDTH-1:0]          in_inst [IN_WIDTH];
   logic [IN_WIDTH-1:0][OFF_W-1:0] slot_off;
   logic [OFF_W-1:0]               batch_n;
   logic [PTR_W-1:0]               wr_idx  [IN_WIDTH];

   assign in_inst[0] = in_inst_0;
   assign in_inst[1] = in_inst_1;
   assign in_inst[2] = in_inst_2;
   assign in_inst[3] = in_inst_3;

   inst_compact #(
      .N     (IN_WIDTH),
      .OFF_W (OFF_W)
   ) u_compact (
      .mask   (in_inst_valid),
      .offset (slot_off),
      .total  (batch_n)
   );

   // Room for a whole batch is judged on the registered count, ignoring any same-cycle dequeue.
   assign in_ready = (count <= CNT_W'(DEPTH - IN_WIDTH));
   assign do_enq   = (|in_inst_valid) && in_ready && !flush;
   assign do_deq   = dec_ready && !flush;

   // Number of entries entering and leaving this cycle.
   always_comb begin
      enq_n = do_enq ? CNT_W'(batch_n) : '0;
      deq_n = '0;
      if (do_deq) begin
         deq_n = (count >= CNT_W'(2)) ? CNT_W'(2) : count;
      end
   end

   // Valid slots land on consecutive entries from tail; pointer arithmetic wraps at DEPTH.
   always_comb begin
      for (int i = 0; i < IN_WIDTH; i++) begin
         wr_idx[i] = tail + PTR_W'(slot_off[i]);
      end
   end

   // Queue pointers and occupancy; flush wins over enqueue and dequeue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(deq_n);
         tail  <= tail + PTR_W'(enq_n);
         count <= count + enq_n - deq_n;
      end
   end

   // Entry storage is left unreset; the PC comes from the original slot index, not the packed position.
   always_ff @(posedge clk) begin
      if (do_enq) begin
         for (int i = 0; i < IN_WIDTH; i++) begin
            if (in_inst_valid[i]) begin
               mem_inst[wr_idx[i]] <= in_inst[i];
               mem_pc[wr_idx[i]]   <= in_pc + ADDR_WIDTH'(INST_BYTES * i);
            end
         end
      end
   end

   assign head_p1      = head + PTR_W'(1);
   assign out_valid[0] = (count != '0);
   assign out_valid[1] = (count >= CNT_W'(2));
   assign out_inst_0   = out_valid[0] ? mem_inst[head]    : '0;
   assign out_pc_0     = out_valid[0] ? mem_pc[head]      : '0;
   assign out_inst_1   = out_valid[1] ? mem_inst[head_p1] : '0;
   assign out_pc_1     = out_valid[1] ? mem_pc[head_p1]   : '0;

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Circular instruction queue between the fetch stage and decode. Each cycle it accepts a batch of up to `IF_BATCH_SIZE` fetched instructions, given as per-slot words plus a valid mask, and compacts the valid ones into program order. Decode then drains up to two instructions per cycle in order. A flush from the back end, on a redirect, empties the queue.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; must be a power of two and at least `IN_WIDTH`.
- `IN_WIDTH`, `IF_BATCH_SIZE` (4): slots per fetch batch.
- `INST_WIDTH`, 32: instruction word width.
- `ADDR_WIDTH`, `INST_ADDR_WIDTH` (32): PC width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  discard all entries.
- `in_inst_0..3`  in  `INST_WIDTH`  batch slot words.
- `in_pc`  in  `ADDR_WIDTH`  PC of slot 0.
- `in_inst_valid`  in  `IN_WIDTH`  per-slot valid mask; any pattern is legal.
- `in_ready`  out  1  space exists for a full batch.
- `out_inst_0/1`  out  `INST_WIDTH`  oldest and second-oldest entry.
- `out_pc_0/1`  out  `ADDR_WIDTH`  PCs of those entries.
- `out_valid`  out  2  bit0 is set when count ≥ 1; bit1 is set when count ≥ 2.
- `dec_ready`  in  1  decode consumes every valid output this cycle.

## Operation
- Each entry stores {inst, pc}. State is `head`, `tail` (log2 DEPTH bits, wrap modulo DEPTH) and `count` (log2 DEPTH + 1 bits).
- Enqueue when `|in_inst_valid && in_ready && !flush`.
  - The valid slots are written to consecutive entries starting at `tail`, in ascending slot order.
  - The entry for slot i stores PC `in_pc + 4*i`. The offset comes from the original slot index, not the compacted position.
  - `tail` advances by popcount(`in_inst_valid`).
- `in_ready = (DEPTH - count) >= IN_WIDTH`. This is combinational from the registered `count`. Acceptance is all-or-nothing; there is no partial enqueue.
- Dequeue when `dec_ready && !flush`. The dequeue count is min(count, 2); `head` advances by that amount.
- Enqueue and dequeue in the same cycle: both apply, and `count_next = count + enq_n - deq_n`. `in_ready` uses the pre-dequeue `count`, so it is conservative.
- `flush` takes priority over both enqueue and dequeue. On a flush, `head = tail = 0` and `count = 0` at the next edge. Input presented in the flush cycle is dropped.
- Outputs read combinationally from entries `head` and `head+1` (mod DEPTH). When the corresponding `out_valid` bit is 0, the `out_inst`/`out_pc` lane is driven to 0.
- If `in_inst_valid` is nonzero while `in_ready` is 0, the batch is ignored. Fetch must hold it and retry.

## Timing
- Reset values: `head = tail = count = 0`, `out_valid = 00`, all `out_inst`/`out_pc` = 0, `in_ready = 1`. Entry storage is not reset.
- Latency: an instruction written at edge N appears on the outputs in the cycle after edge N. There is no same-cycle bypass from input to output.
- Wrap-around: a batch that straddles entry DEPTH-1 continues at entry 0. A read at `head = DEPTH-1` takes lane 1 from entry 0.
- Full: `in_ready` drops once count > DEPTH - IN_WIDTH. With DEPTH 16 that means count ≥ 13.
- Empty with `dec_ready` high: no change.
- Reset asserted mid-operation clears all state immediately, without waiting for `clk`.

## Structure
- `riscv_define.v` gains `IB_DEPTH` and `IB_OUT_WIDTH` (2). `IF_BATCH_SIZE`, `INST_ADDR_WIDTH` and `INST_WIDTH` are reused from it.
- One sub-module, `inst_compact`: combinational. It takes the 4-bit mask and produces, per slot, a write offset (prefix popcount) plus the total count. It is reusable by the IF batching logic.

## Test plan
- Reset, then one batch with mask 1111, `in_pc` = 0x100 → the next cycle shows `out_valid` = 11 with PCs 0x100/0x104; `dec_ready` for 2 cycles empties the queue and `out_valid` returns to 00.
- Mask 1010, `in_pc` = 0x200 → the queue holds exactly 2 entries with PCs 0x204 and 0x20C, in that order.
- Four batches of 1111 with no dequeue → count 16 and `in_ready` = 0. A further batch is dropped: count stays 16.
- Fill to 14, then alternate enqueue 1111 with 2-per-cycle dequeue around `tail` wrap → the PC sequence on the outputs is strictly +4 with no gaps or duplicates.
- Enqueue, `dec_ready` and `flush` asserted in the same cycle → count 0 and `out_valid` 00 at the next cycle; the flushed batch never appears.
- Assert `rst` asynchronously between edges with count 7 → `out_valid` goes to 00 and `in_ready` to 1 without waiting for `clk`.
